// File: rtl/activation_scheduler_if.sv
// Bundle of the scheduler's vector handshakes and shared-activation-unit link.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready; no storage here.
interface activation_scheduler_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   in_z;
    logic [W-1:0]     act_z;
    logic [W-1:0]     act_a;
    logic             out_valid;
    logic             out_ready;
    logic [N*W-1:0]   out_a;
    logic             busy;
    logic [CW-1:0]    idx;

    // Scheduler side
    modport slave (
        input  in_valid, in_z, act_a, out_ready,
        output in_ready, act_z, out_valid, out_a, busy, idx
    );

    // Upstream/downstream/activation-unit side
    modport master (
        output in_valid, in_z, act_a, out_ready,
        input  in_ready, act_z, out_valid, out_a, busy, idx
    );
endinterface

// File: rtl/activation_scheduler.sv
// Time-multiplexes one shared combinational activation unit over an N-element vector.
// Latency: capture edge = cycle 0, RUN on cycles 1..N, out_valid from cycle N+1; one vector per N+2 cycles.
// Backpressure: in_ready low from capture until the result is taken; out_a held in DONE until out_ready.
module activation_scheduler #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    activation_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  zbuf [N];
    logic [W-1:0]  rbuf [N];
    logic          capture;

    // A vector is only taken while idle; in_valid in RUN/DONE has no effect.
    assign capture = (state_q == IDLE) && bus.in_valid;

    // State and element counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand buffer: private snapshot of in_z so upstream may change it after capture
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) zbuf[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < N; i++) zbuf[i] <= bus.in_z[W*i +: W];
        end
    end

    // Result buffer: one activated element written per RUN cycle, kept after hand-off
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) rbuf[i] <= '0;
        end else if (state_q == RUN) begin
            rbuf[cnt_q] <= bus.act_a;
        end
    end

    // Next-state and counter logic; counter stops at N-1 and never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q == LAST) state_d = DONE;
                else               cnt_d   = cnt_q + CW'(1);
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore output decode from registered state, counter and buffers
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        bus.act_z     = '0;
        bus.idx       = '0;
        bus.out_a     = '0;
        for (int i = 0; i < N; i++) bus.out_a[W*i +: W] = rbuf[i];
        case (state_q)
            IDLE: bus.in_ready = 1'b1;
            RUN: begin
                bus.busy  = 1'b1;
                bus.act_z = zbuf[cnt_q];
                bus.idx   = cnt_q;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
            end
            default: bus.in_ready = 1'b0;
        endcase
    end

endmodule
